// File: rtl/register_scoreboard.sv
// Multi-port integer register file with per-register busy scoreboard.
// Claim/release tracking, flush and a registered busy population count.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   raddr/rdata/rbusy  NRD combinational read ports (data + outstanding claim)
//   wren/waddr/wdata   NWR write ports, highest index wins on collisions
//   claim_valid/addr   mark a register busy for a long-latency op
//   claim_ready        claim can be accepted this cycle
//   flush              clear every busy bit, drop any claim this cycle
//   busy_count         number of busy registers
module register_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wren,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*XLEN-1:0]   wdata,
    input  logic                  claim_valid,
    input  logic [AW-1:0]         claim_addr,
    output logic                  claim_ready,
    input  logic                  flush,
    output logic [AW:0]           busy_count
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     count_q, count_d;

    logic [NREG-1:0] wr_hit;
    logic [XLEN-1:0] wr_data [NREG];
    logic            claim_nz;
    logic            claim_acc;

    // Per-register view of this cycle's writes; ascending port order
    // lets the highest enabled port overwrite lower ones.
    always_comb begin
        logic [AW-1:0] wa;
        wa     = '0;
        wr_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_data[r] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            wa = waddr[j*AW +: AW];
            if (wren[j] && (wa != '0)) begin
                wr_hit[wa]  = 1'b1;
                wr_data[wa] = wdata[j*XLEN +: XLEN];
            end
        end
    end

    assign claim_nz = (claim_addr != '0);

    // Under reset the cleared scoreboard would accept anything.
    assign claim_ready = ~rst
                       | (~flush & (~claim_nz
                                    | wr_hit[claim_addr]
                                    | ~busy_q[claim_addr]));

    assign claim_acc = claim_valid & claim_ready & ~flush & claim_nz;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = wr_hit[r] ? wr_data[r] : regs_q[r];
        end
        regs_d[0] = '0;

        // Release first, then claim, so a same-edge claim keeps the bit set.
        busy_d = busy_q & ~wr_hit;
        if (flush) begin
            busy_d = '0;
        end else if (claim_acc) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        count_d = '0;
        for (int r = 0; r < NREG; r++) begin
            count_d = count_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count = count_q;

    always_comb begin
        logic [AW-1:0] ra;
        ra    = '0;
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            if (rst && (ra != '0)) begin
                if ((BYPASS != 0) && wr_hit[ra]) begin
                    rdata[i*XLEN +: XLEN] = wr_data[ra];
                end else begin
                    rdata[i*XLEN +: XLEN] = regs_q[ra];
                    rbusy[i]              = busy_q[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Scoreboard bench for register_scoreboard: bypass and no-bypass
// instances share stimulus; a reference model predicts each cycle.
module tb_register_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NWR-1:0]      wren;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                claim_valid;
    logic [AW-1:0]       claim_addr;
    logic                flush;

    logic [NRD*XLEN-1:0] rdata1, rdata0;
    logic [NRD-1:0]      rbusy1, rbusy0;
    logic                cr1, cr0;
    logic [AW:0]         bc1, bc0;

    always #5 clk = ~clk;

    register_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .raddr(raddr), .rdata(rdata1), .rbusy(rbusy1),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .claim_ready(cr1), .flush(flush), .busy_count(bc1)
    );

    register_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst),
        .raddr(raddr), .rdata(rdata0), .rbusy(rbusy0),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .claim_ready(cr0), .flush(flush), .busy_count(bc0)
    );

    typedef struct {
        logic [NRD*XLEN-1:0] rd1;
        logic [NRD-1:0]      rb1;
        logic [NRD*XLEN-1:0] rd0;
        logic [NRD-1:0]      rb0;
        logic                cr;
        logic [AW:0]         bc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mregs [NREG];
    bit          mbusy [NREG];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rdata_byp",  rdata1, e.rd1);
            chk("rbusy_byp",  rbusy1, e.rb1);
            chk("rdata_nob",  rdata0, e.rd0);
            chk("rbusy_nob",  rbusy0, e.rb0);
            chk("claim_rdy",  cr1,    e.cr);
            chk("claim_rdy0", cr0,    e.cr);
            chk("busy_cnt",   bc1,    e.bc);
            chk("busy_cnt0",  bc0,    e.bc);
        end
    end

    function automatic bit written(logic [AW-1:0] a, output logic [31:0] d);
        bit hit = 0;
        d = '0;
        if (a == 0) return 0;
        for (int j = 0; j < NWR; j++) begin
            if (wren[j] && waddr[j*AW +: AW] == a) begin
                hit = 1;
                d   = wdata[j*XLEN +: XLEN];
            end
        end
        return hit;
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] d;
        logic [AW-1:0] a;
        int          n = 0;
        e.rd1 = '0; e.rb1 = '0; e.rd0 = '0; e.rb0 = '0;
        for (int i = 0; i < NRD; i++) begin
            a = raddr[i*AW +: AW];
            if (rst && a != 0) begin
                e.rd0[i*XLEN +: XLEN] = mregs[a];
                e.rb0[i]              = mbusy[a];
                if (written(a, d)) begin
                    e.rd1[i*XLEN +: XLEN] = d;
                end else begin
                    e.rd1[i*XLEN +: XLEN] = mregs[a];
                    e.rb1[i]              = mbusy[a];
                end
            end
        end
        if (!rst)                      e.cr = 1;
        else if (flush)                e.cr = 0;
        else if (claim_addr == 0)      e.cr = 1;
        else if (written(claim_addr, d)) e.cr = 1;
        else                           e.cr = !mbusy[claim_addr];
        for (int r = 0; r < NREG; r++) n += int'(mbusy[r]);
        e.bc = (AW+1)'(n);
        return e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mregs[r] = '0;
            mbusy[r] = 0;
        end
    endtask

    task automatic model_update(bit cr);
        for (int j = 0; j < NWR; j++) begin
            if (wren[j] && waddr[j*AW +: AW] != 0) begin
                mregs[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
                mbusy[waddr[j*AW +: AW]] = 0;
            end
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) mbusy[r] = 0;
        end else if (claim_valid && cr && claim_addr != 0) begin
            mbusy[claim_addr] = 1;
        end
    endtask

    task automatic step();
        exp_t e;
        e = predict();
        q.push_back(e);
        @(posedge clk);
        if (rst) model_update(e.cr);
        #1;
    endtask

    task automatic clr();
        raddr = '0; wren = '0; waddr = '0; wdata = '0;
        claim_valid = 0; claim_addr = '0; flush = 0;
    endtask

    task automatic rd(int i, int a);
        raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic wr(int j, int a, logic [31:0] d);
        wren[j]               = 1'b1;
        waddr[j*AW +: AW]     = AW'(a);
        wdata[j*XLEN +: XLEN] = d;
    endtask

    task automatic claim(int a);
        claim_valid = 1;
        claim_addr  = AW'(a);
    endtask

    initial begin
        rst = 0;
        clr();
        model_reset();
        @(posedge clk);
        #1;
        rd(0, 5); rd(1, 3);
        step();
        #2 rst = 1;
        #2;
        @(posedge clk);
        #1;

        clr(); wr(0, 5, 32'hDEADBEEF); step();
        clr(); rd(0, 5); rd(1, 0); wr(0, 0, 32'h1); step();
        clr(); rd(0, 0); rd(1, 5); step();

        clr(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); step();
        clr(); rd(0, 7); step();

        clr(); claim(9); rd(0, 9); step();
        clr(); claim(9); rd(0, 9); step();
        clr(); claim_addr = 9; wr(0, 9, 32'h55); rd(0, 9); step();
        clr(); rd(0, 9); step();

        clr(); claim(3); step();
        clr(); claim(3); wr(1, 3, 32'hAB); rd(0, 3); step();
        clr(); rd(0, 3); step();

        clr(); claim(1); step();
        clr(); claim(2); step();
        clr(); claim(4); rd(0, 1); rd(1, 2); step();
        clr(); flush = 1; claim(6); rd(0, 6); rd(1, 4); step();
        clr(); rd(0, 6); rd(1, 1); step();

        for (int k = 0; k < 400; k++) begin
            clr();
            for (int i = 0; i < NRD; i++) rd(i, $urandom_range(0, 7));
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 2) == 0)
                    wr(j, $urandom_range(0, 7), $urandom());
            claim_valid = $urandom_range(0, 1) == 1;
            claim_addr  = AW'($urandom_range(0, 7));
            flush       = $urandom_range(0, 15) == 0;
            step();
        end

        clr(); claim(10); step();
        clr(); rd(0, 10); rd(1, 5); wr(0, 10, 32'h77); claim(11);
        rst = 0;
        model_reset();
        step();
        step();
        clr();
        #2 rst = 1;
        #2;
        @(posedge clk);
        #1;
        clr(); rd(0, 10); rd(1, 5); step();

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
